wb_trace_fifo: RTL and testbench
================================

// Module: wb_trace_fifo
// PURPOSE
//  Downstream of the processor top level. Captures every retired register write-back
//  as a {PCValue, WriteData} pair into a FIFO, then drains it to a debug/checker port
//  over a valid/ready handshake. Lets the bench and on-board debug logic consume
//  retirement traces at their own rate without stalling the core.
// PARAMETERS
//  DEPTH   8   entries; power of 2, >= 2
//  DATA_W  32  width of PCValue and WriteData
//  DROP_W  16  width of the saturating drop counter
// PORTS
//  Clk        in   1                clock; all state updates on rising edge
//  Rst        in   1                asynchronous, active-low reset
//  Clear      in   1                synchronous flush
//  CaptureEn  in   1                write-back valid this cycle (RegWrite of the WB stage)
//  PCValue    in   DATA_W           PC of the retiring instruction
//  WriteData  in   DATA_W           value written to the register file
//  OutValid   out  1                head entry available
//  OutReady   in   1                consumer accepts the head entry
//  OutPC      out  DATA_W           head entry PC
//  OutData    out  DATA_W           head entry write data
//  Count      out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//  Full       out  1                Count == DEPTH
//  Empty      out  1                Count == 0
//  DropCount  out  DROP_W           captures lost because the FIFO was full; saturates
// BEHAVIOUR
//  - Reset (Rst=0): acts immediately, without waiting for a clock edge. Clears the
//    pointers, sets Count=0, DropCount=0, OutValid=0, OutPC=0, OutData=0, Empty=1,
//    Full=0. Storage contents are don't-care. A reset in mid-drain discards every entry.
//  - Push = CaptureEn && (!Full || Pop).
//  - Pop = OutValid && OutReady.
//  - First-word-fall-through:
//    - OutValid = !Empty.
//    - OutPC/OutData show the head entry whenever OutValid=1, and hold 0 when the FIFO
//      is empty.
//    - A push into an empty FIFO at edge N drives OutValid=1 in the cycle after edge N
//      (one-cycle latency).
//  - Push and Pop in the same cycle:
//    - Count is unchanged.
//    - This is legal when Full; no drop occurs.
//    - When Empty, the pop is not possible (OutValid=0), so only the push happens.
//  - Drop: if CaptureEn && Full && !Pop, the entry is discarded and DropCount increments.
//    DropCount holds at 2^DROP_W-1 once it reaches that value.
//  - Head stability: OutPC/OutData and OutValid must not change while OutValid=1 and
//    OutReady=0.
//  - Pointer width is $clog2(DEPTH). Pointers wrap from DEPTH-1 to 0. Count is kept as
//    a separate register and is never derived from the pointers alone.
//  - Clear: at the next edge it empties the FIFO and sets DropCount=0. Clear takes
//    priority over a Push or Pop in the same cycle; that cycle's capture is lost and
//    is not counted as a drop.
//  - Full and Empty are decoded from the registered Count. There are no combinational
//    paths from CaptureEn to Full or to Empty.
//  - Only OutValid, OutPC and OutData may depend combinationally on internal registers
//    through the read mux. OutReady never feeds OutValid combinationally.
// STRUCTURE
//  - Shared header trace_defs.vh: DATA_W, default DEPTH and DROP_W, and a trace entry
//    width macro TRACE_W = 2*DATA_W.
//  - One sub-module, trace_ram: DEPTH x TRACE_W storage with a synchronous write port
//    and an asynchronous read port. No reset on its storage array.
//  - The top holds the pointers, Count, DropCount, the push/pop/clear logic and the
//    output mux.
// TESTING
//  1. Rst=0 for 2 cycles, then 1 -> OutValid=0, Count=0, Empty=1, DropCount=0, OutPC=0.
//  2. Single capture: PCValue=0x40, WriteData=5, CaptureEn=1 for 1 cycle, OutReady=0
//     -> next cycle OutValid=1, OutPC=0x40, OutData=5, Count=1. These values hold for
//     5 cycles; then OutReady=1 for 1 cycle -> Empty=1.
//  3. Fill and overflow (DEPTH=8): 10 consecutive captures with PC=0,4,..,36 and
//     OutReady=0 -> Full=1, Count=8, DropCount=2. Draining 8 entries returns
//     PC 0..28 in order.
//  4. Wrap and simultaneous push/pop: keep Count=8 with CaptureEn=1 and OutReady=1
//     for 20 cycles -> Count stays 8, DropCount unchanged. The output sequence is
//     strictly in capture order across the pointer wrap.
//  5. Clear and reset mid-operation:
//     - Count=5 with Clear=1 and CaptureEn=1 in the same cycle -> next cycle Count=0,
//       DropCount=0.
//     - Separately, Count=3 and Rst pulsed low between edges -> OutValid drops to 0
//       before the next edge.
//  6. Saturation (DROP_W=4): 20 overflow captures while full -> DropCount=15 and
//     holds there.

Source files
------------

// File: rtl/wb_trace_fifo_pkg.sv
// Shared definitions for the write-back trace FIFO: default sizes, entry width helper
// and the per-cycle FIFO operation encoding.
package wb_trace_fifo_pkg;

    localparam int unsigned DEF_DEPTH  = 8;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_DROP_W = 16;

    typedef enum logic [1:0] {
        OpNone = 2'b00,
        OpPush = 2'b01,
        OpPop  = 2'b10,
        OpBoth = 2'b11
    } fifo_op_e;

    // A trace entry is {PC, write data}.
    function automatic int unsigned trace_w(input int unsigned data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/wb_trace_fifo_trace_ram.sv
// Trace entry storage: synchronous write, asynchronous read, no reset on the array.
module wb_trace_fifo_trace_ram #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TRACE_W = 64,
    parameter int unsigned ADDR_W  = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [ADDR_W-1:0]  i_waddr,
    input  logic [TRACE_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0]  i_raddr,
    output logic [TRACE_W-1:0] o_rdata
);

    logic [TRACE_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/wb_trace_fifo.sv
// Retirement trace FIFO: captures {PC, write data} on every write-back and drains it
// first-word-fall-through over a valid/ready port, counting captures lost while full.
module wb_trace_fifo
    import wb_trace_fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DROP_W = DEF_DROP_W
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Clear,
    input  logic                     CaptureEn,
    input  logic [DATA_W-1:0]        PCValue,
    input  logic [DATA_W-1:0]        WriteData,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [DATA_W-1:0]        OutPC,
    output logic [DATA_W-1:0]        OutData,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Full,
    output logic                     Empty,
    output logic [DROP_W-1:0]        DropCount
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned TRACE_W = trace_w(DATA_W);

    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [DROP_W-1:0]  r_drop;

    logic               w_push, w_pop, w_drop;
    fifo_op_e           w_op;
    logic [TRACE_W-1:0] w_rd_entry;

    assign Full     = (r_count == CNT_W'(DEPTH));
    assign Empty    = (r_count == '0);
    assign OutValid = !Empty;

    assign w_pop  = OutValid && OutReady;
    // A full FIFO still accepts a capture when the head leaves in the same cycle.
    assign w_push = CaptureEn && (!Full || w_pop);
    assign w_drop = CaptureEn && Full && !w_pop;
    assign w_op   = fifo_op_e'({w_pop, w_push});

    wb_trace_fifo_trace_ram #(
        .DEPTH   (DEPTH),
        .TRACE_W (TRACE_W),
        .ADDR_W  (PTR_W)
    ) u_ram (
        .i_clk   (Clk),
        .i_we    (w_push && !Clear),
        .i_waddr (r_wr_ptr),
        .i_wdata ({PCValue, WriteData}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_entry)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= '0;
        end else if (Clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case (w_op)
                OpPush:  r_count <= r_count + CNT_W'(1);
                OpPop:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + DROP_W'(1);
            end
        end
    end

    // Head entry is forced to zero while empty so stale storage never leaks out.
    assign OutPC     = OutValid ? w_rd_entry[TRACE_W-1:DATA_W] : '0;
    assign OutData   = OutValid ? w_rd_entry[DATA_W-1:0]       : '0;
    assign Count     = r_count;
    assign DropCount = r_drop;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed and random checks of wb_trace_fifo against a queue-based reference model.
module tb_wb_trace_fifo;

    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Clear = 1'b0;
    logic        CaptureEn = 1'b0;
    logic [31:0] PCValue = '0;
    logic [31:0] WriteData = '0;
    logic        OutReady = 1'b0;

    logic        OutValid, Full, Empty;
    logic [31:0] OutPC, OutData;
    logic [3:0]  Count;
    logic [15:0] DropCount;

    logic        s_valid, s_full, s_empty;
    logic [31:0] s_pc, s_data;
    logic [3:0]  s_count;
    logic [3:0]  s_drop;

    int n_tests = 0;
    int n_fail  = 0;

    ent_t q[$];
    int   drops = 0;

    always #5 Clk = ~Clk;

    wb_trace_fifo u_dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Clear     (Clear),
        .CaptureEn (CaptureEn),
        .PCValue   (PCValue),
        .WriteData (WriteData),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .OutPC     (OutPC),
        .OutData   (OutData),
        .Count     (Count),
        .Full      (Full),
        .Empty     (Empty),
        .DropCount (DropCount)
    );

    wb_trace_fifo #(
        .DROP_W (4)
    ) u_sat (
        .Clk       (Clk),
        .Rst       (Rst),
        .Clear     (Clear),
        .CaptureEn (CaptureEn),
        .PCValue   (PCValue),
        .WriteData (WriteData),
        .OutValid  (s_valid),
        .OutReady  (OutReady),
        .OutPC     (s_pc),
        .OutData   (s_data),
        .Count     (s_count),
        .Full      (s_full),
        .Empty     (s_empty),
        .DropCount (s_drop)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_pc, exp_data;
        int          sz;
        sz       = q.size();
        exp_pc   = (sz > 0) ? q[0].pc   : 32'h0;
        exp_data = (sz > 0) ? q[0].data : 32'h0;
        chk({tag, ".valid"}, 64'(OutValid), 64'(sz > 0));
        chk({tag, ".pc"},    64'(OutPC),    64'(exp_pc));
        chk({tag, ".data"},  64'(OutData),  64'(exp_data));
        chk({tag, ".count"}, 64'(Count),    64'(sz));
        chk({tag, ".full"},  64'(Full),     64'(sz == DEPTH));
        chk({tag, ".empty"}, 64'(Empty),    64'(sz == 0));
        chk({tag, ".drop"},  64'(DropCount), 64'((drops > 65535) ? 65535 : drops));
        chk({tag, ".sdrop"}, 64'(s_drop),   64'((drops > 15) ? 15 : drops));
        chk({tag, ".scnt"},  64'(s_count),  64'(sz));
    endtask

    // Applies one cycle of stimulus, advances the model, then checks after the edge.
    task automatic cycle(input logic ce, input logic [31:0] pc, input logic [31:0] wd,
                         input logic rdy, input logic clr, input string tag);
        bit was_full, pop;
        ent_t e;
        CaptureEn = ce;
        PCValue   = pc;
        WriteData = wd;
        OutReady  = rdy;
        Clear     = clr;
        was_full  = (q.size() == DEPTH);
        pop       = (q.size() > 0) && rdy;
        if (clr) begin
            q.delete();
            drops = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (ce) begin
                if (!was_full || pop) begin
                    e.pc   = pc;
                    e.data = wd;
                    q.push_back(e);
                end else begin
                    drops++;
                end
            end
        end
        @(posedge Clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input logic rdy, input string tag);
        cycle(1'b0, 32'h0, 32'h0, rdy, 1'b0, tag);
    endtask

    initial begin
        // Reset held for two cycles
        Rst = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check_all("reset");
        Rst = 1'b1;
        idle(1'b0, "post_reset");

        // Single capture, held head, then pop
        cycle(1'b1, 32'h40, 32'd5, 1'b0, 1'b0, "single");
        chk("single.pc_const", 64'(OutPC), 64'h40);
        for (int i = 0; i < 5; i++) idle(1'b0, "hold");
        idle(1'b1, "single_pop");
        chk("single.empty_const", 64'(Empty), 64'd1);

        // Fill and overflow
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0, "fill");
        chk("fill.count_const", 64'(Count), 64'd8);
        chk("fill.drop_const", 64'(DropCount), 64'd2);
        for (int i = 0; i < 8; i++) begin
            chk("drain.pc_const", 64'(OutPC), 64'(i * 4));
            idle(1'b1, "drain");
        end

        // Sustained push+pop while full across pointer wraps
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h100 + 32'(i * 4), $urandom, 1'b0, 1'b0, "refill");
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 32'h200 + 32'(i * 4), $urandom, 1'b1, 1'b0, "both");
        chk("both.count_const", 64'(Count), 64'd8);

        // Clear with simultaneous capture at Count=5
        for (int i = 0; i < 3; i++) idle(1'b1, "to5");
        chk("to5.count_const", 64'(Count), 64'd5);
        cycle(1'b1, 32'h300, 32'h1, 1'b1, 1'b1, "clear");
        chk("clear.count_const", 64'(Count), 64'd0);

        // Asynchronous reset between edges at Count=3
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h400 + 32'(i * 4), $urandom, 1'b0, 1'b0, "pre_rst");
        CaptureEn = 1'b0;
        OutReady  = 1'b0;
        Rst       = 1'b0;
        q.delete();
        drops = 0;
        #2;
        chk("async_rst.valid", 64'(OutValid), 64'd0);
        check_all("async_rst");
        #1;
        Rst = 1'b1;
        idle(1'b0, "after_rst");

        // Drop counter saturation on the narrow instance
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'(i), $urandom, 1'b0, 1'b0, "sat_fill");
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'h500 + 32'(i), $urandom, 1'b0, 1'b0, "sat_ovf");
        chk("sat.drop_const", 64'(s_drop), 64'd15);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h600, $urandom, 1'b0, 1'b0, "sat_hold");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
